// File: rtl/pe_pkg.sv
// Shared constants for the parallel processing element: default parameters
// and bit positions inside the ctl field.
package pe_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int LANES_DEF  = 4;
    localparam int ACC_W_DEF  = 40;
    localparam int OUT_W_DEF  = 32;

    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;
endpackage

// File: rtl/pe_add_tree.sv
// Combinational signed sum of LANES packed terms, each sign-extended to ACC_W.
module pe_add_tree #(
    parameter int LANES = 4,
    parameter int IN_W  = 32,
    parameter int ACC_W = 40
) (
    input  logic [LANES*IN_W-1:0]  terms,
    output logic signed [ACC_W-1:0] sum
);
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + ACC_W'($signed(terms[i*IN_W +: IN_W]));
        end
    end
endmodule

// File: rtl/parallel_pe.sv
// Two-stage multiply/accumulate dot-product engine with a registered output.
// Optional macro PE_SAT_EN saturates the result to OUT_W and flags ovf_o.
module parallel_pe
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] neuron,
    input  logic [LANES*DATA_W-1:0] weight,
    input  logic [1:0]              ctl,
    input  logic                    vld_i,
    output logic                    rdy_o,
    output logic [OUT_W-1:0]        result,
    output logic                    ovf_o,
    output logic                    vld_o,
    input  logic                    rdy_i
);
    localparam int PROD_W = 2 * DATA_W;

    logic                     stall;
    logic                     accept;
    logic [LANES*PROD_W-1:0]  prod_c;
    logic [LANES*PROD_W-1:0]  s1_prod;
    logic [1:0]               s1_ctl;
    logic                     s1_vld;
    logic signed [ACC_W-1:0]  lane_sum;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic [OUT_W-1:0]         out_next;
    logic                     ovf_next;

    // A held output blocks the whole pipe so nothing behind it is lost.
    assign stall  = vld_o & ~rdy_i;
    assign rdy_o  = ~stall & ~rst;
    assign accept = vld_i & rdy_o;

    always_comb begin
        prod_c = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_c[i*PROD_W +: PROD_W] =
                PROD_W'($signed(neuron[i*DATA_W +: DATA_W])) *
                PROD_W'($signed(weight[i*DATA_W +: DATA_W]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_prod <= '0;
            s1_ctl  <= '0;
        end else if (!stall) begin
            s1_vld <= accept;
            if (accept) begin
                s1_prod <= prod_c;
                s1_ctl  <= ctl;
            end
        end
    end

    pe_add_tree #(
        .LANES (LANES),
        .IN_W  (PROD_W),
        .ACC_W (ACC_W)
    ) u_add_tree (
        .terms (s1_prod),
        .sum   (lane_sum)
    );

    assign acc_next = s1_ctl[CTL_FIRST] ? lane_sum : acc + lane_sum;

`ifdef PE_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    always_comb begin
        out_next = acc_next[OUT_W-1:0];
        ovf_next = 1'b0;
`ifdef PE_SAT_EN
        if (acc_next > SAT_MAX) begin
            out_next = SAT_MAX[OUT_W-1:0];
            ovf_next = 1'b1;
        end else if (acc_next < SAT_MIN) begin
            out_next = SAT_MIN[OUT_W-1:0];
            ovf_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (!stall && s1_vld) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            ovf_o  <= 1'b0;
            vld_o  <= 1'b0;
        end else if (!stall) begin
            if (s1_vld && s1_ctl[CTL_LAST]) begin
                result <= out_next;
                ovf_o  <= ovf_next;
                vld_o  <= 1'b1;
            end else begin
                vld_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_parallel_pe.sv
// Randomised scoreboard bench for parallel_pe plus directed scenarios.
// Saturation expectations follow PE_SAT_EN when the bench is built with it.
module tb_parallel_pe;
    localparam int DW = 16;
    localparam int L  = 4;
    localparam int AW = 40;
    localparam int OW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [L*DW-1:0] neuron = '0;
    logic [L*DW-1:0] weight = '0;
    logic [1:0]      ctl = '0;
    logic            vld_i = 1'b0;
    logic            rdy_o;
    logic [OW-1:0]   result;
    logic            ovf_o;
    logic            vld_o;
    logic            rdy_i = 1'b1;

    int total = 0;
    int bad   = 0;

    longint      m_acc = 0;
    logic [32:0] exp_q[$];

    parallel_pe #(.DATA_W(DW), .LANES(L), .ACC_W(AW), .OUT_W(OW)) dut (
        .clk    (clk),
        .rst    (rst),
        .neuron (neuron),
        .weight (weight),
        .ctl    (ctl),
        .vld_i  (vld_i),
        .rdy_o  (rdy_o),
        .result (result),
        .ovf_o  (ovf_o),
        .vld_o  (vld_o),
        .rdy_i  (rdy_i)
    );

    always #5 clk = ~clk;

    function automatic longint wrap_acc(input longint x);
        return (x <<< (64 - AW)) >>> (64 - AW);
    endfunction

    function automatic longint dot(input logic [L*DW-1:0] n, input logic [L*DW-1:0] w);
        longint s = 0;
        for (int i = 0; i < L; i++) begin
            logic signed [DW-1:0] a;
            logic signed [DW-1:0] b;
            a = n[i*DW +: DW];
            b = w[i*DW +: DW];
            s = s + longint'(a) * longint'(b);
        end
        return s;
    endfunction

    function automatic logic [32:0] convert(input longint a);
        logic [63:0] bits;
        bits = a;
`ifdef PE_SAT_EN
        if (a > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
        if (a < -64'sd2147483648) return {1'b1, 32'h8000_0000};
`endif
        return {1'b0, bits[31:0]};
    endfunction

    // Reference scoreboard: sees every handshake from the pins at the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            m_acc = 0;
            exp_q.delete();
        end else begin
            if (vld_o === 1'b1 && rdy_i === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_extra: got result=%h ovf=%b, none expected", result, ovf_o);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    if ({ovf_o, result} !== e) begin
                        bad++;
                        $display("FAIL scoreboard: got ovf=%b result=%h, want ovf=%b result=%h",
                                 ovf_o, result, e[32], e[31:0]);
                    end
                end
            end
            if (vld_i === 1'b1 && rdy_o === 1'b1) begin
                longint s;
                s = dot(neuron, weight);
                m_acc = ctl[0] ? wrap_acc(s) : wrap_acc(m_acc + s);
                if (ctl[1]) exp_q.push_back(convert(m_acc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(input int max_cyc);
        for (int n = 0; n < max_cyc; n++) begin
            if (vld_o === 1'b1) return;
            step();
        end
        total++;
        if (vld_o !== 1'b1) begin
            bad++;
            $display("FAIL wait_vld: vld_o=%b after %0d cycles, want 1", vld_o, max_cyc);
        end
    endtask

    function automatic logic [L*DW-1:0] splat(input logic [DW-1:0] v);
        return {L{v}};
    endfunction

    task automatic test_reset();
        rst = 1'b1; vld_i = 1'b0; rdy_i = 1'b1;
        repeat (3) step();
        total++;
        if (rdy_o !== 1'b0) begin bad++; $display("FAIL reset_rdy: rdy_o=%b want 0", rdy_o); end
        rst = 1'b0;
        #1;
        total++;
        if ({vld_o, ovf_o, result} !== {1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_state: vld_o=%b ovf_o=%b result=%h want 0/0/0", vld_o, ovf_o, result);
        end
        total++;
        if (rdy_o !== 1'b1) begin bad++; $display("FAIL reset_rdy_after: rdy_o=%b want 1", rdy_o); end
    endtask

    task automatic test_single();
        rdy_i = 1'b1;
        neuron = {16'd4, 16'd3, 16'd2, 16'd1};
        weight = {16'd8, 16'd7, 16'd6, 16'd5};
        ctl = 2'b11; vld_i = 1'b1;
        step();
        vld_i = 1'b0;
        total++;
        if (vld_o !== 1'b0) begin bad++; $display("FAIL single_early: vld_o=%b want 0", vld_o); end
        step();
        total++;
        if ({vld_o, ovf_o, result} !== {1'b1, 1'b0, 32'd70}) begin
            bad++;
            $display("FAIL single: vld_o=%b ovf_o=%b result=%0d want 1/0/70", vld_o, ovf_o, $signed(result));
        end
        step();
    endtask

    task automatic test_three_beats();
        rdy_i = 1'b1; vld_i = 1'b1;
        neuron = splat(16'd1);  weight = splat(16'd1); ctl = 2'b01; step();
        ctl = 2'b00; step();
        neuron = splat(-16'sd2); weight = splat(16'd3); ctl = 2'b10; step();
        vld_i = 1'b0;
        wait_vld(10);
        total++;
        if (result !== 32'hFFFF_FFF0) begin
            bad++;
            $display("FAIL three_beats: result=%h want fffffff0", result);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] held;
        rdy_i = 1'b0;
        neuron = splat(16'd1); weight = splat(16'd2); ctl = 2'b11; vld_i = 1'b1;
        step();
        vld_i = 1'b0;
        wait_vld(10);
        held = result;
        total++;
        if (held !== 32'd8) begin bad++; $display("FAIL bp_first: result=%0d want 8", held); end
        neuron = splat(16'd3); weight = splat(16'd3); ctl = 2'b11; vld_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({vld_o, rdy_o, result} !== {1'b1, 1'b0, held}) begin
                bad++;
                $display("FAIL bp_hold: vld_o=%b rdy_o=%b result=%h want 1/0/%h", vld_o, rdy_o, result, held);
            end
            step();
        end
        rdy_i = 1'b1;
        #1;
        total++;
        if (rdy_o !== 1'b1) begin bad++; $display("FAIL bp_release: rdy_o=%b want 1", rdy_o); end
        step();
        vld_i = 1'b0;
        wait_vld(10);
        total++;
        if (result !== 32'd36) begin bad++; $display("FAIL bp_pending: result=%0d want 36", result); end
        step();
        total++;
        if (vld_o !== 1'b0) begin bad++; $display("FAIL bp_dup: vld_o=%b want 0", vld_o); end
    endtask

    task automatic test_saturation();
        rdy_i = 1'b1;
        neuron = splat(16'h7FFF); weight = splat(16'h7FFF); ctl = 2'b11; vld_i = 1'b1;
        step();
        vld_i = 1'b0;
        wait_vld(10);
        total++;
`ifdef PE_SAT_EN
        if ({ovf_o, result} !== {1'b1, 32'h7FFF_FFFF}) begin
            bad++;
            $display("FAIL saturation: ovf_o=%b result=%h want 1/7fffffff", ovf_o, result);
        end
`else
        if ({ovf_o, result} !== {1'b0, 32'hFFFC_0004}) begin
            bad++;
            $display("FAIL wrap: ovf_o=%b result=%h want 0/fffc0004", ovf_o, result);
        end
`endif
        step();
    endtask

    task automatic test_reset_mid();
        rdy_i = 1'b1;
        neuron = {48'd0, 16'd10}; weight = {48'd0, 16'd5}; ctl = 2'b01; vld_i = 1'b1;
        step();
        vld_i = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (rdy_o !== 1'b0) begin bad++; $display("FAIL rst_mid_rdy: rdy_o=%b want 0", rdy_o); end
        step();
        total++;
        if (vld_o !== 1'b0) begin bad++; $display("FAIL rst_mid_vld: vld_o=%b want 0", vld_o); end
        rst = 1'b0;
        neuron = {48'd0, 16'd2}; weight = {48'd0, 16'd5}; ctl = 2'b10; vld_i = 1'b1;
        step();
        vld_i = 1'b0;
        wait_vld(10);
        total++;
        if (result !== 32'd10) begin bad++; $display("FAIL rst_mid: result=%0d want 10", result); end
        step();
    endtask

    task automatic test_back_to_back();
        rdy_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            neuron = {$urandom, $urandom}; weight = {$urandom, $urandom};
            ctl = 2'b11; vld_i = 1'b1;
            step();
            if (k >= 1) begin
                total++;
                if (vld_o !== 1'b1) begin bad++; $display("FAIL b2b_gap: beat %0d vld_o=%b want 1", k, vld_o); end
            end
        end
        vld_i = 1'b0;
        step();
        total++;
        if (vld_o !== 1'b1) begin bad++; $display("FAIL b2b_tail: vld_o=%b want 1", vld_o); end
        step();
        total++;
        if (vld_o !== 1'b0) begin bad++; $display("FAIL b2b_end: vld_o=%b want 0", vld_o); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            neuron = {$urandom, $urandom}; weight = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                neuron = splat(16'h7FFF); weight = splat(($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000);
            end
            ctl   = 2'($urandom_range(0, 3));
            vld_i = ($urandom_range(0, 3) != 0);
            rdy_i = ($urandom_range(0, 3) != 0);
            step();
        end
        vld_i = 1'b0; rdy_i = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        step();
        total++;
        if (exp_q.size() != 0 || vld_o !== 1'b0) begin
            bad++;
            $display("FAIL random_drain: pending=%0d vld_o=%b want 0/0", exp_q.size(), vld_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_beats();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
